sign_applier: RTL and testbench

- Sequential back-end of the signed multiplier datapath. Converts an unsigned magnitude product plus a sign bit back into a two's-complement result.
- Inverse of the front-end's sign/absolute-value split.
- Negation is done bit-serially, LSB first, so no wide adder is needed.
- Sits between the unsigned shift-add core and the display/result register. Uses valid/ready handshakes on both sides.

---
 rtl/sign_applier.sv | 164 ++++++++++++++++
 tb/tb_sign_applier.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sign_applier.sv
// -----------------------------------------------------------------------------
// sign_applier
//
// Sequential back-end of the signed multiplier datapath. It takes an unsigned
// magnitude and a sign bit and returns the two's-complement result:
//   result = sign ? (2^WIDTH - mag) mod 2^WIDTH : mag
// Negation is done bit-serially, LSB first, so there is no wide adder. A
// positive operand or a zero magnitude skips the serial path and completes
// one cycle after acceptance.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   upstream presents mag/sign
//   in_ready   out  block can accept an operand (high only in IDLE)
//   mag        in   unsigned magnitude, WIDTH bits, sampled on acceptance
//   sign       in   1 = negative result, sampled on acceptance
//   out_valid  out  result available (high only in DONE)
//   out_ready  in   downstream accepts the result
//   result     out  two's-complement result, registered
//   busy       out  high while in SHIFT or DONE
//   ovf        out  (only with SIGN_APPLIER_OVF_EN) result does not fit in a
//                   signed WIDTH-bit value; registered, valid with out_valid
//
// Optional feature macro: SIGN_APPLIER_OVF_EN adds the ovf output and its
// comparator. Without it, out-of-range operands wrap silently.
// -----------------------------------------------------------------------------
module sign_applier #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mag,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef SIGN_APPLIER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] result_r;
  logic [CW-1:0]    cnt_r;
  logic             seen_one_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             lsb_s;
  logic             out_bit_s;
  logic             zero_mag_s;

`ifdef SIGN_APPLIER_OVF_EN
  logic             ovf_r;

  // Signed range check: positive values must keep the MSB clear, negative
  // values may reach at most 2^(WIDTH-1) in magnitude.
  function automatic logic ovf_calc(input logic s, input logic [WIDTH-1:0] m);
    logic low_nonzero;
    low_nonzero = |m[WIDTH-2:0];
    if (s) begin
      ovf_calc = m[WIDTH-1] & low_nonzero;
    end else begin
      ovf_calc = m[WIDTH-1];
    end
  endfunction

  assign ovf = ovf_r;
`endif

  // Two's-complement negation LSB first: copy bits up to and including the
  // first 1, invert every bit after it.
  assign lsb_s      = shreg_r[0];
  assign out_bit_s  = seen_one_r ? ~lsb_s : lsb_s;
  assign zero_mag_s = (mag == {WIDTH{1'b0}});

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign result    = result_r;

  // Control FSM plus the serial datapath; reset aborts any operation at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      shreg_r     <= {WIDTH{1'b0}};
      result_r    <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      seen_one_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
`ifdef SIGN_APPLIER_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            shreg_r <= mag;
            busy_r  <= 1'b1;
`ifdef SIGN_APPLIER_OVF_EN
            ovf_r   <= ovf_calc(sign, mag);
`endif
            if (!sign || zero_mag_s) begin
              // Nothing to negate (also avoids a negative zero).
              result_r    <= mag;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              cnt_r      <= {CW{1'b0}};
              seen_one_r <= 1'b0;
              state_r    <= SHIFT;
            end
          end
        end

        SHIFT: begin
          // New bits enter at the MSB so bit 0 lands in result[0] after
          // WIDTH shifts.
          result_r   <= {out_bit_s, result_r[WIDTH-1:1]};
          shreg_r    <= {1'b0, shreg_r[WIDTH-1:1]};
          seen_one_r <= seen_one_r | lsb_s;
          cnt_r      <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST) begin
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
`ifdef SIGN_APPLIER_OVF_EN
            ovf_r       <= 1'b0;
`endif
          end
        end

        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_applier.sv
// -----------------------------------------------------------------------------
// tb_sign_applier
//
// Directed self-checking bench for sign_applier (WIDTH=16). Each operation is
// driven through the input handshake, the latency to out_valid is measured,
// result (and ovf when SIGN_APPLIER_OVF_EN is defined) is compared with a
// hand-computed value, and the output handshake is completed. Also covers
// backpressure and an asynchronous reset in the middle of a negation.
// -----------------------------------------------------------------------------
module tb_sign_applier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mag;
  logic        sign;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        busy;
`ifdef SIGN_APPLIER_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  sign_applier #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mag       (mag),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef SIGN_APPLIER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete operation. Called #1 after a rising edge with the block idle.
  // exp_lat counts edges from (and including) the acceptance edge until
  // out_valid is seen; hold is the number of backpressure cycles in DONE.
  task automatic run_op(input string tag, input logic s, input logic [15:0] m,
                        input logic [15:0] exp_res, input int exp_lat,
                        input int hold, input logic exp_ovf);
    int lat;
    check({tag, "_in_ready_idle"}, in_ready, 1);
    sign     = s;
    mag      = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep in_valid up with junk operands: must be ignored outside IDLE.
    mag  = 16'hA5A5;
    sign = ~s;
    lat  = 1;
    while (!out_valid && lat < 40) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_in_ready_busy"}, in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_result"}, result, exp_res);
`ifdef SIGN_APPLIER_OVF_EN
    check({tag, "_ovf"}, ovf, exp_ovf);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_result"}, result, exp_res);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_busy"}, busy, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
`ifdef SIGN_APPLIER_OVF_EN
    check({tag, "_post_ovf"}, ovf, 0);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    mag       = 16'h0000;
    sign      = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_result", result, 16'h0000);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // tag, sign, mag, expected result, latency, backpressure, ovf
    run_op("neg4000", 1'b1, 16'h4000, 16'hC000, 17, 0, 1'b0);
    run_op("byp0023", 1'b0, 16'h0023, 16'h0023,  1, 0, 1'b0);
    run_op("negzero", 1'b1, 16'h0000, 16'h0000,  1, 0, 1'b0);
    run_op("neg8000", 1'b1, 16'h8000, 16'h8000, 17, 0, 1'b0);
    run_op("neg0001", 1'b1, 16'h0001, 16'hFFFF, 17, 5, 1'b0);
    run_op("bypbp",   1'b0, 16'h7FFF, 16'h7FFF,  1, 5, 1'b0);
    run_op("neg00a0", 1'b1, 16'h00A0, 16'hFF60, 17, 0, 1'b0);

    // Reset in the middle of a negation: immediate abort, no edge needed.
    sign     = 1'b1;
    mag      = 16'h1234;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 16'h0000);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("neg1234", 1'b1, 16'h1234, 16'hEDCC, 17, 0, 1'b0);

    // Out-of-range operands: result wraps; ovf flags them when present.
    run_op("neg8001", 1'b1, 16'h8001, 16'h7FFF, 17, 0, 1'b1);
    run_op("byp9000", 1'b0, 16'h9000, 16'h9000,  1, 0, 1'b1);
    run_op("byp3f01", 1'b0, 16'h3F01, 16'h3F01,  1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
